// File: rtl/stroke_player_pkg.sv
// Shared types for the stroke player: coordinate/index widths, FSM state codes,
// and the single-axis step helper used by both axis steppers.
package stroke_player_pkg;

    localparam int unsigned COORD_W = 8;
    localparam int unsigned IDX_W   = 5;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [IDX_W-1:0]   idx_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_MOVE = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } point_t;

    // One unit toward the target; never overshoots, so the range ends are never crossed.
    function automatic coord_t step_toward(input coord_t pos, input coord_t tgt);
        coord_t nxt;
        if (pos < tgt) begin
            nxt = coord_t'(pos + coord_t'(1));
        end else if (pos > tgt) begin
            nxt = coord_t'(pos - coord_t'(1));
        end else begin
            nxt = pos;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/stroke_player_if.sv
// Stroke-table / pen-layer bus between the digit tables, the player and the canvas writer.
interface stroke_player_if;
    import stroke_player_pkg::*;

    logic   start;
    logic   abort;
    idx_t   num_strokes;
    logic   step_tick;
    coord_t seg_start_x;
    coord_t seg_start_y;
    coord_t seg_end_x;
    coord_t seg_end_y;
    logic   seg_pen_down;
    idx_t   seg_idx;
    logic   seg_en;
    coord_t pen_x;
    coord_t pen_y;
    logic   pen_down;
    logic   busy;
    logic   done;

    modport master (
        output start, abort, num_strokes, step_tick,
        output seg_start_x, seg_start_y, seg_end_x, seg_end_y, seg_pen_down,
        input  seg_idx, seg_en, pen_x, pen_y, pen_down, busy, done
    );

    modport slave (
        input  start, abort, num_strokes, step_tick,
        input  seg_start_x, seg_start_y, seg_end_x, seg_end_y, seg_pen_down,
        output seg_idx, seg_en, pen_x, pen_y, pen_down, busy, done
    );

endinterface

// File: rtl/stroke_player_axis_stepper.sv
// One pen coordinate: loaded with a segment start/end, then stepped +/-1 toward the end.
module stroke_player_axis_stepper
    import stroke_player_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load_i,
    input  coord_t load_pos_i,
    input  coord_t load_tgt_i,
    input  logic   step_i,
    output coord_t pos_o,
    output logic   at_end_o
);

    coord_t pos_q, pos_d;
    coord_t tgt_q, tgt_d;

    always_comb begin
        pos_d = pos_q;
        tgt_d = tgt_q;
        if (load_i) begin
            pos_d = load_pos_i;
            tgt_d = load_tgt_i;
        end else if (step_i) begin
            pos_d = step_toward(pos_q, tgt_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q <= '0;
            tgt_q <= '0;
        end else begin
            pos_q <= pos_d;
            tgt_q <= tgt_d;
        end
    end

    assign pos_o    = pos_q;
    assign at_end_o = (pos_q == tgt_q);

endmodule

// File: rtl/stroke_player.sv
// Walks a stroke table entry by entry, pacing the pen toward each segment end
// one unit per step_tick and reporting pen position/state to the canvas side.
module stroke_player
    import stroke_player_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    stroke_player_if.slave  bus
);

    state_e state_q, state_d;
    idx_t   seg_idx_q, seg_idx_d;
    idx_t   num_q, num_d;
    logic   pen_down_q, pen_down_d;
    logic   done_q, done_d;

    logic   load;
    logic   step;
    coord_t pos_x, pos_y;
    logic   x_at_end, y_at_end;
    logic   seg_complete;

    assign seg_complete = x_at_end && y_at_end;

    // Next-state and control; abort overrides everything but reset.
    always_comb begin
        state_d    = state_q;
        seg_idx_d  = seg_idx_q;
        num_d      = num_q;
        pen_down_d = pen_down_q;
        done_d     = 1'b0;
        load       = 1'b0;
        step       = 1'b0;

        if (bus.abort) begin
            state_d    = ST_IDLE;
            pen_down_d = 1'b0;
            seg_idx_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        num_d      = bus.num_strokes;
                        seg_idx_d  = '0;
                        pen_down_d = 1'b0;
                        if (bus.num_strokes == '0) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    load       = 1'b1;
                    pen_down_d = bus.seg_pen_down;
                    state_d    = ST_MOVE;
                end
                ST_MOVE: begin
                    if (seg_complete) begin
                        pen_down_d = 1'b0;
                        if (seg_idx_q == idx_t'(num_q - idx_t'(1))) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            seg_idx_d = idx_t'(seg_idx_q + idx_t'(1));
                            state_d   = ST_LOAD;
                        end
                    end else if (bus.step_tick) begin
                        step = 1'b1;
                    end
                end
                ST_DONE: begin
                    pen_down_d = 1'b0;
                    state_d    = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            seg_idx_q  <= '0;
            num_q      <= '0;
            pen_down_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            seg_idx_q  <= seg_idx_d;
            num_q      <= num_d;
            pen_down_q <= pen_down_d;
            done_q     <= done_d;
        end
    end

    stroke_player_axis_stepper u_axis_x (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load),
        .load_pos_i (bus.seg_start_x),
        .load_tgt_i (bus.seg_end_x),
        .step_i     (step),
        .pos_o      (pos_x),
        .at_end_o   (x_at_end)
    );

    stroke_player_axis_stepper u_axis_y (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load),
        .load_pos_i (bus.seg_start_y),
        .load_tgt_i (bus.seg_end_y),
        .step_i     (step),
        .pos_o      (pos_y),
        .at_end_o   (y_at_end)
    );

    assign bus.seg_idx  = seg_idx_q;
    assign bus.seg_en   = (state_q == ST_LOAD);
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.pen_x    = pos_x;
    assign bus.pen_y    = pos_y;
    assign bus.pen_down = pen_down_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_stroke_player.sv
// Directed bench for stroke_player: digit-3 table, diagonal, slow ticks, zero cases,
// abort, async reset and start-while-busy.
module tb_stroke_player;
    import stroke_player_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    coord_t t_sx [32];
    coord_t t_sy [32];
    coord_t t_ex [32];
    coord_t t_ey [32];
    logic   t_pd [32];

    stroke_player_if bus();

    stroke_player dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.seg_start_x  = t_sx[bus.seg_idx];
    assign bus.seg_start_y  = t_sy[bus.seg_idx];
    assign bus.seg_end_x    = t_ex[bus.seg_idx];
    assign bus.seg_end_y    = t_ey[bus.seg_idx];
    assign bus.seg_pen_down = t_pd[bus.seg_idx];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input idx_t n);
        bus.num_strokes = n;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic clear_table();
        for (int i = 0; i < 32; i++) begin
            t_sx[i] = '0; t_sy[i] = '0; t_ex[i] = '0; t_ey[i] = '0; t_pd[i] = 1'b0;
        end
    endtask

    task automatic set_seg(input int i, input coord_t sx, input coord_t sy,
                           input coord_t ex, input coord_t ey, input logic pd);
        t_sx[i] = sx; t_sy[i] = sy; t_ex[i] = ex; t_ey[i] = ey; t_pd[i] = pd;
    endtask

    // Up-moves total 240, down-moves 440, ends at origin.
    task automatic load_digit3();
        clear_table();
        set_seg(0,   0,   0,  60,  40, 1'b0);
        set_seg(1,  60,  40,  60, 120, 1'b1);
        set_seg(2,  60, 120, 120, 120, 1'b1);
        set_seg(3, 120, 120, 120, 200, 1'b1);
        set_seg(4, 120, 200,  40, 200, 1'b1);
        set_seg(5,  40, 200, 120, 160, 1'b0);
        set_seg(6, 120, 160, 100,  20, 1'b1);
        set_seg(7, 100,  20,   0,   0, 1'b0);
    endtask

    task automatic test_reset();
        logic [31:0] outs;
        outs = {bus.seg_idx, bus.seg_en, bus.pen_x, bus.pen_y, bus.pen_down, bus.busy, bus.done};
        checks++;
        if (outs !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_digit3();
        int steps = 0, down = 0, dones = 0, en_cnt = 0;
        logic [31:0] seen = '0;
        coord_t px, py;
        logic pen_prev, en_prev, fin;
        load_digit3();
        bus.step_tick = 1'b1;
        pulse_start(5'd8);
        fin = 1'b0;
        if (bus.seg_en) begin en_cnt++; seen[bus.seg_idx] = 1'b1; end
        px = bus.pen_x; py = bus.pen_y; pen_prev = bus.pen_down; en_prev = bus.seg_en;
        for (int i = 0; i < 2000 && !fin; i++) begin
            cyc();
            if (((bus.pen_x != px) || (bus.pen_y != py)) && !en_prev) begin
                steps++;
                if (pen_prev) down++;
            end
            if (bus.seg_en) begin en_cnt++; seen[bus.seg_idx] = 1'b1; end
            if (bus.done) dones++;
            if (!bus.busy) fin = 1'b1;
            px = bus.pen_x; py = bus.pen_y; pen_prev = bus.pen_down; en_prev = bus.seg_en;
        end
        checks++;
        if (fin !== 1'b1) begin errors++; $display("FAIL d3_timeout: busy never cleared"); end
        checks++;
        if (steps != 680) begin errors++; $display("FAIL d3_steps: got %0d expected 680", steps); end
        checks++;
        if (down != 440) begin errors++; $display("FAIL d3_pen_down_steps: got %0d expected 440", down); end
        checks++;
        if (dones != 1) begin errors++; $display("FAIL d3_done_count: got %0d expected 1", dones); end
        checks++;
        if (en_cnt != 8 || seen !== 32'h0000_00FF) begin
            errors++;
            $display("FAIL d3_seg_en: got count %0d mask %h expected 8 mask ff", en_cnt, seen);
        end
        checks++;
        if (bus.pen_x !== 8'd0 || bus.pen_y !== 8'd0) begin
            errors++;
            $display("FAIL d3_final_pos: got (%0d,%0d) expected (0,0)", bus.pen_x, bus.pen_y);
        end
    endtask

    task automatic test_diagonal();
        int pen_hi = 0;
        clear_table();
        set_seg(0, 0, 0, 60, 40, 1'b0);
        bus.step_tick = 1'b1;
        pulse_start(5'd1);
        cyc();
        for (int k = 1; k <= 60; k++) begin
            cyc();
            if (bus.pen_down) pen_hi++;
            if (k == 40) begin
                checks++;
                if (bus.pen_x !== 8'd40 || bus.pen_y !== 8'd40) begin
                    errors++;
                    $display("FAIL diag_40: got (%0d,%0d) expected (40,40)", bus.pen_x, bus.pen_y);
                end
            end
        end
        checks++;
        if (bus.pen_x !== 8'd60 || bus.pen_y !== 8'd40) begin
            errors++;
            $display("FAIL diag_60: got (%0d,%0d) expected (60,40)", bus.pen_x, bus.pen_y);
        end
        cyc();
        checks++;
        if (bus.done !== 1'b1 || pen_hi != 0) begin
            errors++;
            $display("FAIL diag_done_pen: got done=%0b pen_hi=%0d expected done=1 pen_hi=0", bus.done, pen_hi);
        end
        cyc();
    endtask

    task automatic test_slow_tick();
        int steps = 0, bad = 0, done_at = -1, dones = 0;
        coord_t px, py;
        logic t, en_prev;
        clear_table();
        set_seg(0, 60, 40, 60, 120, 1'b1);
        bus.step_tick = 1'b0;
        pulse_start(5'd1);
        px = bus.pen_x; py = bus.pen_y; en_prev = bus.seg_en;
        for (int i = 1; i <= 400; i++) begin
            bus.step_tick = (i % 4 == 0);
            t = bus.step_tick;
            cyc();
            if (((bus.pen_x != px) || (bus.pen_y != py)) && !en_prev) begin
                steps++;
                if (!t) bad++;
            end
            if (bus.done) begin dones++; done_at = i; end
            px = bus.pen_x; py = bus.pen_y; en_prev = bus.seg_en;
        end
        bus.step_tick = 1'b0;
        checks++;
        if (steps != 80 || bad != 0) begin
            errors++;
            $display("FAIL slow_steps: got steps=%0d untimed=%0d expected 80 and 0", steps, bad);
        end
        checks++;
        if (dones != 1 || done_at < 319 || done_at > 327) begin
            errors++;
            $display("FAIL slow_done: got count=%0d at=%0d expected 1 at 319..327", dones, done_at);
        end
        checks++;
        if (bus.pen_x !== 8'd60 || bus.pen_y !== 8'd120) begin
            errors++;
            $display("FAIL slow_final: got (%0d,%0d) expected (60,120)", bus.pen_x, bus.pen_y);
        end
    endtask

    task automatic test_zero();
        bus.step_tick = 1'b0;
        pulse_start(5'd0);
        checks++;
        if (bus.done !== 1'b1 || bus.seg_en !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_num: got done=%0b seg_en=%0b busy=%0b expected 1 0 1",
                     bus.done, bus.seg_en, bus.busy);
        end
        cyc();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_num_end: got done=%0b busy=%0b expected 0 0", bus.done, bus.busy);
        end
        clear_table();
        set_seg(0, 5, 5, 5, 5, 1'b1);
        pulse_start(5'd1);
        cyc();
        cyc();
        checks++;
        if (bus.done !== 1'b1 || bus.pen_x !== 8'd5 || bus.pen_y !== 8'd5) begin
            errors++;
            $display("FAIL zero_len: got done=%0b pos=(%0d,%0d) expected 1 (5,5)",
                     bus.done, bus.pen_x, bus.pen_y);
        end
        cyc();
    endtask

    task automatic test_abort();
        int guard = 0, late_done = 0;
        load_digit3();
        bus.step_tick = 1'b1;
        pulse_start(5'd8);
        while (!(bus.seg_en && bus.seg_idx == 5'd1) && guard < 200) begin
            cyc();
            guard++;
        end
        checks++;
        if (guard >= 200) begin errors++; $display("FAIL abort_wait: seg 1 never loaded"); end
        cyc();
        for (int k = 0; k < 30; k++) cyc();
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.pen_down !== 1'b0 || bus.done !== 1'b0 ||
            bus.seg_idx !== 5'd0 || bus.pen_x !== 8'd60 || bus.pen_y !== 8'd70) begin
            errors++;
            $display("FAIL abort_state: got busy=%0b pen=%0b done=%0b idx=%0d pos=(%0d,%0d) expected 0 0 0 0 (60,70)",
                     bus.busy, bus.pen_down, bus.done, bus.seg_idx, bus.pen_x, bus.pen_y);
        end
        for (int k = 0; k < 5; k++) begin
            cyc();
            if (bus.done || bus.busy) late_done++;
        end
        checks++;
        if (late_done != 0) begin errors++; $display("FAIL abort_quiet: got %0d active cycles expected 0", late_done); end
        pulse_start(5'd8);
        checks++;
        if (bus.seg_en !== 1'b1 || bus.seg_idx !== 5'd0) begin
            errors++;
            $display("FAIL abort_replay: got seg_en=%0b idx=%0d expected 1 0", bus.seg_en, bus.seg_idx);
        end
        cyc();
        checks++;
        if (bus.pen_x !== 8'd0 || bus.pen_y !== 8'd0) begin
            errors++;
            $display("FAIL abort_replay_pos: got (%0d,%0d) expected (0,0)", bus.pen_x, bus.pen_y);
        end
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [31:0] outs;
        clear_table();
        set_seg(0, 60, 40, 60, 120, 1'b1);
        bus.step_tick = 1'b1;
        pulse_start(5'd1);
        for (int k = 0; k < 5; k++) cyc();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        outs = {bus.seg_idx, bus.seg_en, bus.pen_x, bus.pen_y, bus.pen_down, bus.busy, bus.done};
        checks++;
        if (outs !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: got %h expected 0", outs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_start_busy();
        int en_cnt = 0, dones = 0, guard = 0;
        clear_table();
        set_seg(0, 0, 0, 0, 20, 1'b1);
        set_seg(1, 9, 9, 9, 9, 1'b0);
        bus.step_tick = 1'b1;
        pulse_start(5'd1);
        cyc();
        cyc();
        pulse_start(5'd8);
        while (bus.busy && guard < 100) begin
            if (bus.seg_en) en_cnt++;
            if (bus.done) dones++;
            cyc();
            guard++;
        end
        checks++;
        if (en_cnt != 0 || dones != 1 || guard >= 100) begin
            errors++;
            $display("FAIL start_busy: got seg_en=%0d done=%0d guard=%0d expected 0 1 <100",
                     en_cnt, dones, guard);
        end
        checks++;
        if (bus.pen_x !== 8'd0 || bus.pen_y !== 8'd20) begin
            errors++;
            $display("FAIL start_busy_pos: got (%0d,%0d) expected (0,20)", bus.pen_x, bus.pen_y);
        end
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.start        = 1'b0;
        bus.abort        = 1'b0;
        bus.num_strokes  = '0;
        bus.step_tick    = 1'b0;
        clear_table();
        #23;
        test_reset();
        test_digit3();
        cyc();
        test_diagonal();
        test_slow_tick();
        cyc();
        test_zero();
        test_abort();
        cyc();
        test_async_reset();
        test_start_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
